// File: rtl/ghr_controller.sv
// Speculative global-history manager for a gshare predictor: speculative history at fetch,
// per-branch checkpoints in an in-order FIFO, committed history at resolve, 1-cycle repair.
module ghr_controller #(
    parameter  int G_WIDTH = 9,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               predValid,
    input  logic               predTaken,
    input  logic [G_WIDTH:0]   PC,
    output logic [G_WIDTH:0]   index,
    output logic               predReady,
    output logic [PTR_W-1:0]   predTag,
    input  logic               resValid,
    input  logic               resTaken,
    input  logic               resMispredict,
    input  logic               flush,
    output logic [G_WIDTH:0]   specHistory,
    output logic [G_WIDTH:0]   commitHistory,
    output logic [PTR_W:0]     inFlight
);

    typedef enum logic {RUN, RECOVER} state_e;

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [G_WIDTH:0]   spec_q, spec_d;
    logic [G_WIDTH:0]   commit_q, commit_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     cnt_q, cnt_d;

    // The history MSB is shifted out on every restore, so checkpoints keep only the low bits.
    logic [G_WIDTH-1:0] ckpt_q [DEPTH];

    logic accept, resolve, mispredict, recover, push;

    assign predReady  = (state_q == RUN) && (cnt_q < FULL);
    assign accept     = predValid && predReady;
    assign resolve    = resValid && (cnt_q != '0);
    assign mispredict = resolve && resMispredict;
    assign recover    = flush || mispredict;
    assign push       = accept && !recover;

    assign index         = PC ^ spec_q;
    assign predTag       = tail_q;
    assign specHistory   = spec_q;
    assign commitHistory = commit_q;
    assign inFlight      = cnt_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        spec_d   = spec_q;
        commit_d = commit_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;

        if (resolve) begin
            commit_d = {commit_q[G_WIDTH-1:0], resTaken};
            head_d   = head_q + 1'b1;
        end

        if (flush) begin
            spec_d  = commit_d;
            head_d  = tail_q;
            cnt_d   = '0;
            state_d = RECOVER;
        end else if (mispredict) begin
            spec_d  = {ckpt_q[head_q], resTaken};
            head_d  = tail_q;
            cnt_d   = '0;
            state_d = RECOVER;
        end else begin
            state_d = RUN;
            if (accept) begin
                spec_d = {spec_q[G_WIDTH-1:0], predTaken};
                tail_d = tail_q + 1'b1;
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            unique case ({accept, resolve})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            spec_q   <= '0;
            commit_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            spec_q   <= spec_d;
            commit_q <= commit_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: checkpoint storage has no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            ckpt_q[tail_q] <= spec_q[G_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_ghr_controller.sv
// Self-checking bench for ghr_controller: queue-based checkpoint model feeds a scoreboard
// of expected post-edge state, plus directed checks of the documented scenarios.
module tb_ghr_controller;

    localparam int G_WIDTH = 9;
    localparam int DEPTH   = 4;
    localparam int PTR_W   = 2;
    localparam int W       = G_WIDTH + 1;

    logic             clk;
    logic             rst_n;
    logic             predValid, predTaken;
    logic [W-1:0]     PC;
    logic [W-1:0]     index;
    logic             predReady;
    logic [PTR_W-1:0] predTag;
    logic             resValid, resTaken, resMispredict, flush;
    logic [W-1:0]     specHistory, commitHistory;
    logic [PTR_W:0]   inFlight;

    ghr_controller #(.G_WIDTH(G_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .predValid(predValid), .predTaken(predTaken), .PC(PC),
        .index(index), .predReady(predReady), .predTag(predTag),
        .resValid(resValid), .resTaken(resTaken), .resMispredict(resMispredict),
        .flush(flush), .specHistory(specHistory), .commitHistory(commitHistory),
        .inFlight(inFlight)
    );

    typedef struct packed {
        logic [W-1:0]   spec;
        logic [W-1:0]   commit;
        logic [PTR_W:0] cnt;
        logic           ready;
    } exp_t;

    exp_t             sb_q[$];
    logic [W-1:0]     m_spec, m_commit;
    logic [W-1:0]     m_ckpt[$];
    logic [PTR_W-1:0] m_tail;
    bit               m_rec;
    int               checks = 0;
    int               errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !m_rec && (m_ckpt.size() < DEPTH);
    endfunction

    task automatic idle_inputs();
        predValid = 0; predTaken = 0; PC = '0;
        resValid = 0; resTaken = 0; resMispredict = 0; flush = 0;
    endtask

    task automatic model_reset();
        m_spec = '0; m_commit = '0; m_tail = '0; m_rec = 0;
        m_ckpt.delete();
        sb_q.delete();
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic pv, input logic pt, input logic [W-1:0] pc,
                        input logic rv, input logic rt, input logic rm, input logic fl);
        exp_t         e;
        logic         acc, res, mis;
        logic [W-1:0] nc;
        predValid = pv; predTaken = pt; PC = pc;
        resValid = rv; resTaken = rt; resMispredict = rm; flush = fl;
        #1;
        check("index", index, pc ^ m_spec);
        check("predReady", predReady, m_ready());
        check("predTag", predTag, m_tail);

        acc = pv && m_ready();
        res = rv && (m_ckpt.size() > 0);
        mis = res && rm;
        nc  = res ? {m_commit[W-2:0], rt} : m_commit;
        if (fl || mis) begin
            m_spec = fl ? nc : {m_ckpt[0][W-2:0], rt};
            m_ckpt.delete();
            m_rec = 1;
        end else begin
            if (res) void'(m_ckpt.pop_front());
            if (acc) begin
                m_ckpt.push_back(m_spec);
                m_spec = {m_spec[W-2:0], pt};
                m_tail++;
            end
            m_rec = 0;
        end
        m_commit = nc;
        e.spec   = m_spec;
        e.commit = m_commit;
        e.cnt    = (PTR_W + 1)'(m_ckpt.size());
        e.ready  = m_ready();
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        idle_inputs();
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("specHistory", specHistory, e.spec);
            check("commitHistory", commitHistory, e.commit);
            check("inFlight", inFlight, e.cnt);
            check("predReady_next", predReady, e.ready);
        end
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 0;
        #1;
        model_reset();
        check("rst_spec", specHistory, 0);
        check("rst_commit", commitHistory, 0);
        check("rst_inflight", inFlight, 0);
        check("rst_ready", predReady, 1);
        check("rst_tag", predTag, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();

        // Reset, then T,N,T at PC 0x3FF.
        reset_dut();
        step(1, 1, 10'h3FF, 0, 0, 0, 0);
        step(1, 0, 10'h3FF, 0, 0, 0, 0);
        PC = 10'h3FF;
        #1;
        check("index_cycle3", index, 10'h3FD);
        step(1, 1, 10'h3FF, 0, 0, 0, 0);
        check("spec_TNT", specHistory, 10'h005);
        check("inflight_3", inFlight, 3);

        // Fill, refuse a fifth, pop-only on resolve+predValid, push next cycle.
        step(1, 0, 10'h155, 0, 0, 0, 0);
        check("full_ready", predReady, 0);
        check("full_cnt", inFlight, 4);
        step(1, 1, 10'h0AA, 0, 0, 0, 0);
        check("full_refused", inFlight, 4);
        step(1, 1, 10'h0AA, 1, 1, 0, 0);
        check("pop_only", inFlight, 3);
        step(1, 1, 10'h0AA, 0, 0, 0, 0);
        check("push_next", inFlight, 4);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, i[0], 0, 0);

        // Mispredict on the oldest of T,T,T with resTaken=0.
        reset_dut();
        for (int i = 0; i < 3; i++) step(1, 1, 10'h012, 0, 0, 0, 0);
        step(1, 1, 10'h012, 1, 0, 1, 0);
        check("mis_spec", specHistory, 10'h000);
        check("mis_commit", commitHistory, 10'h000);
        check("mis_inflight", inFlight, 0);
        check("mis_ready_low", predReady, 0);
        step(1, 1, 10'h012, 0, 0, 0, 0);
        check("mis_ready_high", predReady, 1);
        check("mis_no_push", inFlight, 0);

        // Two correct resolves (T,N) then flush with two in flight.
        reset_dut();
        step(1, 1, 10'h001, 0, 0, 0, 0);
        step(1, 0, 10'h002, 0, 0, 0, 0);
        step(1, 1, 10'h003, 0, 0, 0, 0);
        step(1, 1, 10'h004, 0, 0, 0, 0);
        step(0, 0, '0, 1, 1, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        check("commit_TN", commitHistory, 10'h002);
        check("flush_pre_cnt", inFlight, 2);
        step(1, 1, 10'h005, 0, 0, 0, 1);
        check("flush_spec", specHistory, 10'h002);
        check("flush_inflight", inFlight, 0);
        step(0, 0, '0, 0, 0, 0, 0);

        // Twelve taken predictions with interleaved resolves: saturation and tag wrap.
        reset_dut();
        step(1, 1, 10'h100, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(1, 1, W'(i), 1, 1, 0, 0);
        check("spec_sat", specHistory, 10'h3FF);
        check("sat_inflight", inFlight, 1);

        // Randomised traffic including mispredicts, flushes and overlaps.
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)),
                 W'($urandom_range(0, 1023)), logic'($urandom_range(0, 9) < 4),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 19) < 3),
                 logic'($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset mid-stream with three in flight.
        reset_dut();
        for (int i = 0; i < 3; i++) step(1, 1, 10'h2A0, 0, 0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        check("async_spec", specHistory, 0);
        check("async_commit", commitHistory, 0);
        check("async_inflight", inFlight, 0);
        check("async_ready", predReady, 1);
        check("async_tag", predTag, 0);
        model_reset();
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        step(0, 0, '0, 1, 1, 1, 0);
        check("empty_res_spec", specHistory, 0);
        check("empty_res_commit", commitHistory, 0);
        check("empty_res_cnt", inFlight, 0);
        check("empty_res_ready", predReady, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghr_controller.md
# ghr_controller

Speculative global-history manager for the gshare predictor. It shifts each predicted conditional-branch outcome into a speculative history register at fetch and forms the PHT index as PC XOR speculative history. It keeps one history checkpoint per in-flight branch in an in-order FIFO and maintains a committed history at resolve. On a mispredict or pipeline flush it restores the speculative history in one cycle. It sits between fetch (prediction side) and the branch unit (resolution side).

## Interface

- G_WIDTH, 9: history/index MSB; history and index are G_WIDTH+1 bits.
- DEPTH, 4: checkpoint FIFO entries, power of two ≥ 2; PTR_W = log2(DEPTH).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- predValid  in  1  fetch presents a predicted conditional branch.
- predTaken  in  1  predicted direction (1 = taken).
- PC  in  G_WIDTH+1  low PC bits of the fetched branch.
- index  out  G_WIDTH+1  PHT index = PC ^ specHistory, combinational.
- predReady  out  1  controller can accept a prediction this cycle.
- predTag  out  PTR_W  FIFO slot assigned to an accepted prediction (= tail pointer).
- resValid  in  1  oldest in-flight branch resolves this cycle.
- resTaken  in  1  actual outcome of the resolving branch.
- resMispredict  in  1  resolving branch was mispredicted; qualified by resValid.
- flush  in  1  non-branch pipeline flush (exception/interrupt).
- specHistory  out  G_WIDTH+1  speculative global history.
- commitHistory  out  G_WIDTH+1  committed global history.
- inFlight  out  PTR_W+1  occupied checkpoint entries.

## Operation

- Reset: specHistory = 0, commitHistory = 0, head = tail = 0, inFlight = 0, state = RUN, predReady = 1.
- FSM states:
  - RUN → RECOVER on an accepted mispredict or on flush.
  - RECOVER → RUN unconditionally after 1 cycle.
- predReady = (state == RUN) && (inFlight < DEPTH). A pop in the same cycle does not free a slot for a push.
- Accept = predValid && predReady. On accept:
  - ckpt[tail] ← specHistory (pre-shift value).
  - tail++ (wraps modulo DEPTH).
  - specHistory ← {specHistory[G_WIDTH-1:0], predTaken}; MSB discarded.
- Resolve = resValid && inFlight > 0. resValid with inFlight = 0 is ignored: no state change.
- On resolve:
  - commitHistory ← {commitHistory[G_WIDTH-1:0], resTaken}.
  - head++.
- Resolve with resMispredict:
  - specHistory ← {ckpt[head][G_WIDTH-1:0], resTaken}.
  - FIFO emptied: head = tail, inFlight = 0.
  - An accept in the same cycle is squashed: no push, no shift.
- Flush:
  - specHistory ← commitHistory next value, which includes any same-cycle resolve.
  - FIFO emptied; same-cycle accept squashed.
  - flush has priority over mispredict; the results are equal when both apply.
- Resolve without mispredict plus accept in the same cycle: push and pop both occur, inFlight unchanged, specHistory shifts by predTaken.
- inFlight: +1 on push only, −1 on pop only; set to 0 on recovery.
- In RECOVER: predictions are refused; resolve and flush are still honoured (FIFO is empty, so resolve is ignored).
- Invariant: with no mispredict, commitHistory after resolving branch k equals the checkpoint of branch k+1.

## Timing

- index: combinational from PC and the specHistory register, zero latency. After an accept, index reflects the new history on the next cycle.
- Prediction acceptance: single cycle; predTag valid in the accept cycle.
- Recovery:
  - specHistory is correct on the cycle after the mispredict/flush edge.
  - predReady is low for exactly that cycle (RECOVER), then high.
- rst_n asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight checkpoints are lost; outputs are valid on release.
- Checkpoint storage is not reset (don't-care contents); only pointers and histories are reset.

## Test plan

- Reset, then accept 3 predictions T,N,T with PC = 0x3FF: specHistory = 0x005; index in cycle 3 = 0x3FF ^ 0x002 = 0x3FD; predTag = 0,1,2; inFlight = 3.
- Fill with DEPTH=4 accepts: predReady = 0 with inFlight = 4; a 5th predValid is not accepted. Resolve + predValid in the same cycle: pop only, inFlight = 3; the push is accepted next cycle.
- From specHistory = 0x000, predict T,T,T, then resolve the first as mispredict with resTaken = 0:
  - specHistory = 0x000, commitHistory = 0x000, inFlight = 0.
  - predReady low for 1 cycle, then high.
  - predValid in the mispredict cycle is not pushed.
- Resolve two correct branches (T,N) from commitHistory = 0 → commitHistory = 0x002. Then flush with 2 in flight: specHistory = 0x002, inFlight = 0.
- 12 consecutive taken predictions: specHistory saturates at 0x3FF (older bits shifted out). Pointers wrap: predTag sequence 0,1,2,3,0 across interleaved resolves.
- Assert rst_n low mid-stream with 3 in flight: all outputs return to reset values asynchronously. resValid after release with inFlight = 0 causes no state change.
